// File: rtl/systolic_2x2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_2x2_ctrl
// Brief    : Start/clear/feed/wait/hold sequencer for a 2x2 systolic multiply
//            array, with timeout-qualified result hand-off.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_2x2_ctrl #(
   parameter int DW      = 32,
   parameter int RW      = 64,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] a00,
   input  logic [DW-1:0] a01,
   input  logic [DW-1:0] a10,
   input  logic [DW-1:0] a11,
   input  logic [DW-1:0] b00,
   input  logic [DW-1:0] b01,
   input  logic [DW-1:0] b10,
   input  logic [DW-1:0] b11,
   output logic          busy,
   output logic          arr_rst,
   output logic          arr_load_in,
   output logic [DW-1:0] arr_row0,
   output logic [DW-1:0] arr_row1,
   output logic [DW-1:0] arr_col0,
   output logic [DW-1:0] arr_col1,
   input  logic [RW-1:0] arr_res00,
   input  logic [RW-1:0] arr_res01,
   input  logic [RW-1:0] arr_res10,
   input  logic [RW-1:0] arr_res11,
   input  logic [3:0]    arr_carry,
   input  logic          arr_done,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [RW-1:0] c00,
   output logic [RW-1:0] c01,
   output logic [RW-1:0] c10,
   output logic [RW-1:0] c11,
   output logic [3:0]    carry,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_FEED = 3'd2,
      S_WAIT = 3'd3,
      S_HOLD = 3'd4
   } state_t;

   localparam logic [7:0] c_T_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] c_K_LAST = 2'd2;

   logic          r_rst_meta;
   logic          r_rst_n;
   state_t        r_state;
   logic [1:0]    r_k;
   logic [7:0]    r_t;
   logic [DW-1:0] r_a00, r_a01, r_a10, r_a11;
   logic [DW-1:0] r_b00, r_b01, r_b10, r_b11;
   logic          r_busy;
   logic          r_arr_rst;
   logic          r_load;
   logic [DW-1:0] r_row0, r_row1, r_col0, r_col1;
   logic          r_res_valid;
   logic          r_err;
   logic [RW-1:0] r_c00, r_c01, r_c10, r_c11;
   logic [3:0]    r_carry;

   logic [1:0]    w_sel;
   logic          w_load;
   logic [DW-1:0] w_row0, w_row1, w_col0, w_col1;

   // Reset asserts asynchronously and releases two clocks after rst rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   // Slot selected for the next registered feed word; slot 3 is the idle
   // (all-zero, load low) word that closes the skewed sequence.
   always_comb begin
      w_sel  = (r_state == S_CLR) ? 2'd0 : 2'(r_k + 2'd1);
      w_load = (w_sel != 2'd3);
      w_row0 = '0;
      w_row1 = '0;
      w_col0 = '0;
      w_col1 = '0;
      case (w_sel)
         2'd0: begin
            w_row0 = r_a00;
            w_col0 = r_b00;
         end
         2'd1: begin
            w_row0 = r_a01;
            w_row1 = r_a10;
            w_col0 = r_b10;
            w_col1 = r_b01;
         end
         2'd2: begin
            w_row1 = r_a11;
            w_col1 = r_b11;
         end
         default: begin
            w_row0 = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_t         <= '0;
         r_a00       <= '0;
         r_a01       <= '0;
         r_a10       <= '0;
         r_a11       <= '0;
         r_b00       <= '0;
         r_b01       <= '0;
         r_b10       <= '0;
         r_b11       <= '0;
         r_busy      <= 1'b0;
         r_arr_rst   <= 1'b0;
         r_load      <= 1'b0;
         r_row0      <= '0;
         r_row1      <= '0;
         r_col0      <= '0;
         r_col1      <= '0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         r_c00       <= '0;
         r_c01       <= '0;
         r_c10       <= '0;
         r_c11       <= '0;
         r_carry     <= '0;
      end else begin
         r_arr_rst <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a00     <= a00;
                  r_a01     <= a01;
                  r_a10     <= a10;
                  r_a11     <= a11;
                  r_b00     <= b00;
                  r_b01     <= b01;
                  r_b10     <= b10;
                  r_b11     <= b11;
                  r_busy    <= 1'b1;
                  r_arr_rst <= 1'b1;
                  r_state   <= S_CLR;
               end
            end
            S_CLR: begin
               r_k     <= 2'd0;
               r_load  <= w_load;
               r_row0  <= w_row0;
               r_row1  <= w_row1;
               r_col0  <= w_col0;
               r_col1  <= w_col1;
               r_state <= S_FEED;
            end
            S_FEED: begin
               r_load <= w_load;
               r_row0 <= w_row0;
               r_row1 <= w_row1;
               r_col0 <= w_col0;
               r_col1 <= w_col1;
               if (r_k == c_K_LAST) begin
                  r_t     <= '0;
                  r_state <= S_WAIT;
               end else begin
                  r_k <= 2'(r_k + 2'd1);
               end
            end
            S_WAIT: begin
               r_t <= 8'(r_t + 8'd1);
               if (arr_done) begin
                  r_c00       <= arr_res00;
                  r_c01       <= arr_res01;
                  r_c10       <= arr_res10;
                  r_c11       <= arr_res11;
                  r_carry     <= arr_carry;
                  r_err       <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end else if (r_t == c_T_LAST) begin
                  r_err       <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign arr_rst     = r_arr_rst;
   assign arr_load_in = r_load;
   assign arr_row0    = r_row0;
   assign arr_row1    = r_row1;
   assign arr_col0    = r_col0;
   assign arr_col1    = r_col1;
   assign res_valid   = r_res_valid;
   assign c00         = r_c00;
   assign c01         = r_c01;
   assign c10         = r_c10;
   assign c11         = r_c11;
   assign carry       = r_carry;
   assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_2x2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_2x2_ctrl
// Brief    : Self-checking bench: behavioural 2x2 array plus feed/result queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_2x2_ctrl;
   localparam int DW  = 32;
   localparam int RW  = 64;
   localparam int TMO = 16;
   localparam int DLY = 4;

   typedef struct packed {
      logic [3:0][DW-1:0] a;
      logic [3:0][DW-1:0] b;
      logic [3:0][RW-1:0] c;
      logic [3:0]         cy;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] r0;
      logic [DW-1:0] r1;
      logic [DW-1:0] c0;
      logic [DW-1:0] c1;
   } feed_t;

   typedef struct packed {
      logic [3:0][RW-1:0] c;
      logic [3:0]         cy;
      logic               e;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
   logic [DW-1:0] b00 = '0, b01 = '0, b10 = '0, b11 = '0;
   logic          busy, arr_rst, arr_load_in;
   logic [DW-1:0] arr_row0, arr_row1, arr_col0, arr_col1;
   logic [RW-1:0] arr_res00, arr_res01, arr_res10, arr_res11;
   logic [3:0]    arr_carry;
   logic          arr_done;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [RW-1:0] c00, c01, c10, c11;
   logic [3:0]    carry;
   logic          err;

   int    total = 0;
   int    bad = 0;
   vec_t  vt [4];
   feed_t fq [$];
   res_t  rq [$];
   res_t  last;
   logic  rv_q = 1'b0;
   bit    done_en = 1'b1;
   bit    spur = 1'b0;

   always #5 clk = ~clk;

   systolic_2x2_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a00(a00), .a01(a01), .a10(a10), .a11(a11),
      .b00(b00), .b01(b01), .b10(b10), .b11(b11),
      .busy(busy), .arr_rst(arr_rst), .arr_load_in(arr_load_in),
      .arr_row0(arr_row0), .arr_row1(arr_row1),
      .arr_col0(arr_col0), .arr_col1(arr_col1),
      .arr_res00(arr_res00), .arr_res01(arr_res01),
      .arr_res10(arr_res10), .arr_res11(arr_res11),
      .arr_carry(arr_carry), .arr_done(arr_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .carry(carry), .err(err)
   );

   // Behavioural output-stationary 2x2 array: PE(i,j) sees row i delayed j
   // cycles and column j delayed i cycles.
   logic [RW:0]   acc00, acc01, acc10, acc11;
   logic [DW-1:0] r0d, r1d, c0d, c1d;
   logic          ld_q;
   logic          done_r;
   int            dcnt;

   function automatic logic [RW:0] mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
      return (RW+1)'(x) * (RW+1)'(y);
   endfunction

   always @(posedge clk) begin
      if (!rst || arr_rst) begin
         acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
         r0d <= '0; r1d <= '0; c0d <= '0; c1d <= '0;
         ld_q <= 1'b0; done_r <= 1'b0; dcnt <= 0;
      end else begin
         acc00 <= acc00 + mul(arr_row0, arr_col0);
         acc01 <= acc01 + mul(r0d, arr_col1);
         acc10 <= acc10 + mul(arr_row1, c0d);
         acc11 <= acc11 + mul(r1d, c1d);
         r0d <= arr_row0; r1d <= arr_row1; c0d <= arr_col0; c1d <= arr_col1;
         ld_q <= arr_load_in;
         done_r <= 1'b0;
         if (ld_q && !arr_load_in) dcnt <= 1;
         else if (dcnt == DLY) begin
            dcnt <= 0;
            done_r <= done_en;
         end else if (dcnt != 0) dcnt <= dcnt + 1;
      end
   end

   assign arr_res00 = spur ? 64'hDEAD_BEEF_0000_0001 : acc00[RW-1:0];
   assign arr_res01 = spur ? 64'hDEAD_BEEF_0000_0002 : acc01[RW-1:0];
   assign arr_res10 = spur ? 64'hDEAD_BEEF_0000_0003 : acc10[RW-1:0];
   assign arr_res11 = spur ? 64'hDEAD_BEEF_0000_0004 : acc11[RW-1:0];
   assign arr_carry = spur ? 4'hF : {acc00[RW], acc01[RW], acc10[RW], acc11[RW]};
   assign arr_done  = done_r | spur;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [DW-1:0] x00, x01, x10, x11,
                               input logic [DW-1:0] y00, y01, y10, y11,
                               input logic [RW-1:0] z00, z01, z10, z11,
                               input logic [3:0] cy);
      vec_t v;
      v.a[0] = x00; v.a[1] = x01; v.a[2] = x10; v.a[3] = x11;
      v.b[0] = y00; v.b[1] = y01; v.b[2] = y10; v.b[3] = y11;
      v.c[0] = z00; v.c[1] = z01; v.c[2] = z10; v.c[3] = z11;
      v.cy = cy;
      return v;
   endfunction

   always @(negedge clk) begin
      feed_t f;
      res_t  r;
      if (rst && arr_load_in) begin
         if (fq.size() == 0) check("feed_unexpected", 64'(arr_row0), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            f = fq.pop_front();
            check("feed_row0", 64'(arr_row0), 64'(f.r0));
            check("feed_row1", 64'(arr_row1), 64'(f.r1));
            check("feed_col0", 64'(arr_col0), 64'(f.c0));
            check("feed_col1", 64'(arr_col1), 64'(f.c1));
         end
      end
      if (rst && res_valid && !rv_q) begin
         if (rq.size() == 0) check("res_unexpected", 64'(res_valid), 64'd0);
         else begin
            r = rq.pop_front();
            check("res_c00", c00, r.c[0]);
            check("res_c01", c01, r.c[1]);
            check("res_c10", c10, r.c[2]);
            check("res_c11", c11, r.c[3]);
            check("res_carry", 64'(carry), 64'(r.cy));
            check("res_err", 64'(err), 64'(r.e));
         end
      end
      rv_q <= res_valid;
   end

   task automatic drive_ops(input vec_t v);
      a00 = v.a[0]; a01 = v.a[1]; a10 = v.a[2]; a11 = v.a[3];
      b00 = v.b[0]; b01 = v.b[1]; b10 = v.b[2]; b11 = v.b[3];
      fq.push_back('{r0: v.a[0], r1: '0,     c0: v.b[0], c1: '0});
      fq.push_back('{r0: v.a[1], r1: v.a[2], c0: v.b[2], c1: v.b[1]});
      fq.push_back('{r0: '0,     r1: v.a[3], c0: '0,     c1: v.b[3]});
   endtask

   task automatic scramble();
      a00 = $urandom; a01 = $urandom; a10 = $urandom; a11 = $urandom;
      b00 = $urandom; b01 = $urandom; b10 = $urandom; b11 = $urandom;
   endtask

   task automatic run_op(input int idx, input bit tmo, input bit spam, input int hold);
      int   cyc;
      res_t r;
      @(negedge clk);
      drive_ops(vt[idx]);
      if (tmo) r = '{c: last.c, cy: last.cy, e: 1'b1};
      else begin
         r = '{c: vt[idx].c, cy: vt[idx].cy, e: 1'b0};
         last = r;
      end
      rq.push_back(r);
      done_en = !tmo;
      start = 1'b1;
      @(negedge clk);
      if (spam) scramble(); else start = 1'b0;
      check("clr_pulse", 64'(arr_rst), 64'd1);
      check("busy_clr", 64'(busy), 64'd1);
      @(negedge clk);
      if (spam) scramble();
      check("clr_single", 64'(arr_rst), 64'd0);
      check("load_first", 64'(arr_load_in), 64'd1);
      cyc = 1;
      while (!res_valid && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (spam) scramble();
      end
      check("latency", 64'(cyc), tmo ? 64'd20 : 64'd10);
      repeat (hold) @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_c00", c00, r.c[0]);
      check("hold_c11", c11, r.c[3]);
      check("hold_err", 64'(err), 64'(r.e));
      @(negedge clk);
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("release_valid", 64'(res_valid), 64'd0);
      check("release_busy", 64'(busy), 64'd0);
      check("release_err", 64'(err), 64'(r.e));
      check("feed_drained", 64'(fq.size()), 64'd0);
   endtask

   initial begin
      vt[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 4'h0);
      vt[1] = mk(0, 1, 1, 0, 9, 8, 7, 6, 7, 6, 9, 8, 4'h0);
      vt[2] = mk('1, '1, '1, '1, '1, '1, '1, '1,
                 64'hFFFF_FFFC_0000_0002, 64'hFFFF_FFFC_0000_0002,
                 64'hFFFF_FFFC_0000_0002, 64'hFFFF_FFFC_0000_0002, 4'hF);
      vt[3] = mk(2, 0, 0, 3, 10, 20, 30, 40, 20, 40, 90, 120, 4'h0);
      last = '0;

      // Reset state
      #23;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_load", 64'(arr_load_in), 64'd0);
      check("rst_arr_rst", 64'(arr_rst), 64'd0);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_c00", c00, 64'd0);
      check("rst_carry_err", 64'({carry, err}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_valid", 64'(res_valid), 64'd0);

      run_op(0, 1'b0, 1'b0, 10);

      // Spurious done while idle must not be captured
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      check("spur_c00", c00, last.c[0]);
      check("spur_carry", 64'(carry), 64'(last.cy));
      check("spur_valid", 64'(res_valid), 64'd0);
      check("spur_busy", 64'(busy), 64'd0);

      run_op(3, 1'b1, 1'b0, 1);
      run_op(1, 1'b0, 1'b1, 2);
      run_op(2, 1'b0, 1'b0, 1);

      // Reset in the middle of the feed (k=1 on the outputs)
      @(negedge clk);
      drive_ops(vt[1]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_load", 64'(arr_load_in), 64'd0);
      check("midrst_rows", 64'({arr_row0, arr_row1}), 64'd0);
      check("midrst_cols", 64'({arr_col0, arr_col1}), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_c00", c00, 64'd0);
      fq.delete();
      rq.delete();
      last = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      run_op(3, 1'b0, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("res_drained", 64'(rq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/systolic_2x2_ctrl.md
Name: systolic_2x2_ctrl

Overview:
Sequencer for the 2x2 systolic multiply array. It accepts two 2x2 operand matrices A and B through a start handshake and pulses the array's synchronous clear. It then streams skewed row/column operands with load_in asserted, waits for the array's done, and holds the four 65-bit results until the consumer accepts them. It sits between the operand source (DMA/register file) and one systolic_2x2 instance.

Parameters:
DW, 32, operand width (must match array row/col input width)
RW, 64, result width per element (carry is separate)
TIMEOUT, 16, max cycles in WAIT before forcing error completion (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  request a multiply; accepted only in IDLE
a00,a01,a10,a11  in  DW each  matrix A elements, sampled on accept
b00,b01,b10,b11  in  DW each  matrix B elements, sampled on accept
busy  out  1  high in every state except IDLE
arr_rst  out  1  active-high synchronous clear to the array
arr_load_in  out  1  array load_in
arr_row0,arr_row1  out  DW each  array row inputs
arr_col0,arr_col1  out  DW each  array column inputs
arr_res00,arr_res01,arr_res10,arr_res11  in  RW each  array results
arr_carry  in  4  {c00,c01,c10,c11} array carries
arr_done  in  1  array done pulse
res_valid  out  1  results held, awaiting consumer
res_ready  in  1  consumer accepts results
c00,c01,c10,c11  out  RW each  captured results
carry  out  4  captured carries, same order as arr_carry
err  out  1  qualifies res_valid; 1 = timeout, results invalid

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, arr_rst=0, arr_load_in=0, all arr_row/col=0, res_valid=0, err=0, c**=0, carry=0; internal counters=0. Deassertion is synchronised internally with a 2-flop release.
- All outputs are registered.
- States: IDLE, CLR, FEED, WAIT, HOLD.
- IDLE:
  - On start=1, latch A and B, go to CLR.
  - start in any other state is ignored; no queueing.
- CLR: arr_rst=1 for exactly one cycle, then FEED with feed counter k=0.
- FEED: 3 cycles, k=0,1,2, with arr_load_in=1 throughout. Skewed operands per cycle:
  - k=0: row0=a00, row1=0, col0=b00, col1=0
  - k=1: row0=a01, row1=a10, col0=b10, col1=b01
  - k=2: row0=0, row1=a11, col0=0, col1=b11
  - After k=2, go to WAIT with row/col=0, arr_load_in=0 and timeout counter t=0.
- WAIT: row/col held at 0, load_in=0, t increments each cycle.
  - arr_done=1: capture arr_res**/arr_carry into c**/carry, err=0, go to HOLD.
  - Else t==TIMEOUT-1: c** and carry are left unchanged, err=1, go to HOLD.
  - arr_done and timeout in the same cycle: arr_done wins.
- HOLD:
  - res_valid=1; c**, carry and err are stable.
  - res_ready=1: res_valid drops the next cycle; go to IDLE, keeping err until the next capture.
  - start asserted while in HOLD is ignored.
- arr_done outside WAIT is ignored; no capture and no state change.
- Latency: start accepted at edge N → arr_rst high in cycle N+1 → load_in high in N+2..N+4 → WAIT from N+5. res_valid rises the cycle after arr_done is sampled.
- Minimum start-to-start spacing is 6 cycles plus the array done latency plus one HOLD cycle.
- Reset asserted mid-operation: immediate return to IDLE, all outputs at their reset values, and any held result is lost.

Test Plan:
- Reset with rst=0 → all outputs 0, busy=0; release rst → still IDLE.
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], start, with an array model giving done 4 cycles after the last feed → feed sequence (1,0,5,0), (2,3,7,6), (0,4,0,8). Then res_valid with c00=19, c01=22, c10=43, c11=50, err=0, carry=0.
- Hold res_ready=0 for 10 cycles after res_valid → outputs stable and busy=1. Pulse res_ready → res_valid=0 next cycle, busy=0.
- Array never asserts done, TIMEOUT=16 → res_valid with err=1 exactly 16 cycles after WAIT entry, and c** keep their previous values.
- Assert start during FEED, WAIT and HOLD → no effect on the feed sequence or results. Spurious arr_done in IDLE → no capture.
- Drive rst=0 in the middle of FEED (k=1) → arr_load_in and arr_row/col=0 immediately, state IDLE. A new start afterwards completes normally.
